// File: rtl/controlador_contador_if.sv
// Request/command bus and contador16 control bus for controlador_contador.
// The controller connects through the slave modport.
// The requesters and the counter connect through the master modport.
interface controlador_contador_if #(
    parameter int W = 16
) ();
    // Requester side
    logic         REQ0;
    logic [1:0]   CMD0;
    logic [W-1:0] DATO0;
    logic         REQ1;
    logic [1:0]   CMD1;
    logic [W-1:0] DATO1;
    logic         ABORT;
    logic [1:0]   ACK;
    logic         BUSY;
    logic         DONE;
    logic         DONE_ID;
    logic         WRAP;
    // contador16 side
    logic         CNT_RCO;
    logic         CNT_ENB;
    logic [1:0]   CNT_MODO;
    logic [W-1:0] CNT_D;

    modport slave (
        input  REQ0, CMD0, DATO0, REQ1, CMD1, DATO1, ABORT, CNT_RCO,
        output ACK, BUSY, DONE, DONE_ID, WRAP, CNT_ENB, CNT_MODO, CNT_D
    );

    modport master (
        output REQ0, CMD0, DATO0, REQ1, CMD1, DATO1, ABORT, CNT_RCO,
        input  ACK, BUSY, DONE, DONE_ID, WRAP, CNT_ENB, CNT_MODO, CNT_D
    );
endinterface

// File: rtl/controlador_contador.sv
// controlador_contador: arbitrates two requesters onto one contador16.
// It drives the counter enable, mode and load data for the granted command.
// It reports completion, the owning requester, and whether the run ended on RCO.
// Optional macro CTRL_PRIO_FIJA_EN selects fixed priority, where requester 0 always wins.
// When the macro is undefined, arbitration is round-robin.
module controlador_contador #(
    parameter int W  = 16,
    parameter int SW = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    controlador_contador_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b11;

    state_t         state_q, state_d;
    logic [1:0]     cmd_q;
    logic           id_q;
    logic [SW-1:0]  rem_q;
    logic           freerun_q;
`ifndef CTRL_PRIO_FIJA_EN
    logic           last_q;
`endif

    // Registered outputs and their next values
    logic [1:0]     ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           done_id_q, done_id_d;
    logic           wrap_q, wrap_d;
    logic           cnt_enb_q, cnt_enb_d;
    logic [1:0]     cnt_modo_q, cnt_modo_d;
    logic [W-1:0]   cnt_d_q, cnt_d_d;

    logic           any_req_s;
    logic           gnt_id_s;
    logic [1:0]     gnt_cmd_s;
    logic [W-1:0]   gnt_dato_s;
    logic           rco_hit_s;
    logic           steps_end_s;
    logic           last_cyc_s;

    // Arbitration: choose the winner among the pending requests
    always_comb begin
        any_req_s = bus.REQ0 | bus.REQ1;
        gnt_id_s  = 1'b0;
`ifdef CTRL_PRIO_FIJA_EN
        if (bus.REQ0) begin
            gnt_id_s = 1'b0;
        end else begin
            gnt_id_s = 1'b1;
        end
`else
        if (bus.REQ0 && bus.REQ1) begin
            gnt_id_s = ~last_q;
        end else if (bus.REQ0) begin
            gnt_id_s = 1'b0;
        end else begin
            gnt_id_s = 1'b1;
        end
`endif
        gnt_cmd_s  = gnt_id_s ? bus.CMD1  : bus.CMD0;
        gnt_dato_s = gnt_id_s ? bus.DATO1 : bus.DATO0;
    end

    // Detect whether the current EXEC cycle is the last enabled one
    always_comb begin
        rco_hit_s   = (cmd_q != CMD_LOAD) && bus.CNT_RCO;
        steps_end_s = (cmd_q != CMD_LOAD) && !freerun_q && (rem_q == SW'(1));
        last_cyc_s  = (cmd_q == CMD_LOAD) || bus.ABORT || rco_hit_s || steps_end_s;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (last_cyc_s) begin
                    state_d = FIN;
                end else begin
                    state_d = EXEC;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values; mode and load data hold unless a new command is granted
    always_comb begin
        ack_d      = 2'b00;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        done_id_d  = done_id_q;
        wrap_d     = wrap_q;
        cnt_enb_d  = (state_d == EXEC);
        cnt_modo_d = cnt_modo_q;
        cnt_d_d    = cnt_d_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    ack_d      = gnt_id_s ? 2'b10 : 2'b01;
                    cnt_modo_d = gnt_cmd_s;
                    if (gnt_cmd_s == CMD_LOAD) begin
                        cnt_d_d = gnt_dato_s;
                    end else begin
                        cnt_d_d = cnt_d_q;
                    end
                end else begin
                    ack_d = 2'b00;
                end
            end
            EXEC: begin
                if (last_cyc_s) begin
                    done_id_d = id_q;
                    wrap_d    = rco_hit_s;
                end else begin
                    done_id_d = done_id_q;
                end
            end
            FIN:     ack_d = 2'b00;
            default: ack_d = 2'b00;
        endcase
    end

    // Command context: latch the winner, then count down the remaining steps
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_q     <= 2'b00;
            id_q      <= 1'b0;
            rem_q     <= '0;
            freerun_q <= 1'b0;
`ifndef CTRL_PRIO_FIJA_EN
            last_q    <= 1'b1;
`endif
        end else if ((state_q == IDLE) && any_req_s) begin
            cmd_q     <= gnt_cmd_s;
            id_q      <= gnt_id_s;
            rem_q     <= gnt_dato_s[SW-1:0];
            freerun_q <= (gnt_dato_s[SW-1:0] == '0);
`ifndef CTRL_PRIO_FIJA_EN
            last_q    <= gnt_id_s;
`endif
        end else if ((state_q == EXEC) && !freerun_q) begin
            rem_q <= rem_q - SW'(1);
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_enb_q  <= 1'b0;
            cnt_modo_q <= 2'b00;
            cnt_d_q    <= '0;
        end else begin
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            wrap_q     <= wrap_d;
            cnt_enb_q  <= cnt_enb_d;
            cnt_modo_q <= cnt_modo_d;
            cnt_d_q    <= cnt_d_d;
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.DONE_ID  = done_id_q;
    assign bus.WRAP     = wrap_q;
    assign bus.CNT_ENB  = cnt_enb_q;
    assign bus.CNT_MODO = cnt_modo_q;
    assign bus.CNT_D    = cnt_d_q;

endmodule
